// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the mm:ss countdown timer.
//   state_t  : FSM state encoding (IDLE=0, RUN=1, PAUSED=2, EXPIRED=3)
//   SEC_W    : width of the seconds and minutes fields
//   SEC_MAX  : largest seconds value (the mod-60 wrap point)
// -----------------------------------------------------------------------------
package countdown_pkg;

  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
// Groups the command strobes, preset value and status outputs of the
// countdown timer. clk and reset are plain ports of the timer itself.
//   tc_time_base : 1 Hz one-clock tick
//   load         : strobe, load {load_min, load_sec}
//   load_min     : preset minutes
//   load_sec     : preset seconds
//   start        : strobe, start / resume counting
//   pause        : strobe, freeze counting
//   q_seconds    : remaining seconds
//   q_minutes    : remaining minutes
//   running      : high while counting
//   expired      : one-clock pulse at 00:00
//   alarm        : held alarm indication
// Modports: master drives commands and reads status; slave is the timer.
// -----------------------------------------------------------------------------
interface countdown_timer_if;
  import countdown_pkg::*;

  logic             tc_time_base;
  logic             load;
  logic [SEC_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic             start;
  logic             pause;
  logic [SEC_W-1:0] q_seconds;
  logic [SEC_W-1:0] q_minutes;
  logic             running;
  logic             expired;
  logic             alarm;

  modport master (
    output tc_time_base, load, load_min, load_sec, start, pause,
    input  q_seconds, q_minutes, running, expired, alarm
  );

  modport slave (
    input  tc_time_base, load, load_min, load_sec, start, pause,
    output q_seconds, q_minutes, running, expired, alarm
  );

endinterface

// File: rtl/down_cnt_mod60.sv
// -----------------------------------------------------------------------------
// down_cnt_mod60
// Seconds digit of the timer: a 6-bit down counter that wraps 0 -> 59.
//   clk        : system clock
//   reset      : synchronous active-high clear to 0
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load (already saturated by the caller)
//   i_en       : decrement by one this clock
//   o_cnt      : current count
//   o_borrow   : high when a decrement wraps 0 -> 59 (minutes must decrement)
// -----------------------------------------------------------------------------
module down_cnt_mod60
  import countdown_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [SEC_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [SEC_W-1:0] o_cnt,
  output logic             o_borrow
);

  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);

  logic [SEC_W-1:0] r_cnt;

  assign o_borrow = i_en && (r_cnt == '0);
  assign o_cnt    = r_cnt;

  // ---- stage p0: seconds register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? SEC_TOP : (r_cnt - 1'b1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// mm:ss countdown timer driven by a 1 Hz time-base tick.
// Parameters:
//   MAX_MIN     : largest minutes value accepted at load (saturates above)
//   ALARM_TICKS : time-base ticks the alarm holds after expiry
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : countdown_timer_if.slave (commands, preset, status outputs)
// Build option:
//   COUNTDOWN_ALARM_EN : when defined, alarm rises with expired and holds for
//                        ALARM_TICKS ticks; when undefined, alarm is tied to 0
//                        and no alarm counter exists.
// Strobe priority: reset > load > pause > start.
// -----------------------------------------------------------------------------
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 10
) (
  input logic               clk,
  input logic               reset,
  countdown_timer_if.slave  bus
);

  localparam logic [SEC_W-1:0] MIN_LIM = SEC_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SEC_LIM = SEC_W'(SEC_MAX);

  if (MAX_MIN < 0 || MAX_MIN > 63 || ALARM_TICKS < 1) begin : g_param_check
    $error("countdown_timer: MAX_MIN must be 0..63 and ALARM_TICKS >= 1");
  end

  function automatic logic [SEC_W-1:0] sat_field(input logic [SEC_W-1:0] v,
                                                 input logic [SEC_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [SEC_W-1:0] r_min;
  logic [SEC_W-1:0] w_sec;
  logic             w_borrow;
  logic             w_cnt_nz;
  logic             w_dec;
  logic             w_last;
  logic             w_start_ok;
  logic             r_running;
  logic             r_expired;

  assign w_cnt_nz   = (r_min != '0) || (w_sec != '0);
  // load and pause both outrank the tick; start only matters outside RUN.
  assign w_dec      = (r_state == ST_RUN) && bus.tc_time_base && !bus.load && !bus.pause;
  assign w_last     = w_dec && (r_min == '0) && (w_sec == SEC_W'(1));
  assign w_start_ok = bus.start && !bus.pause && w_cnt_nz;

  down_cnt_mod60 u_sec (
    .clk        (clk),
    .reset      (reset),
    .i_load     (bus.load),
    .i_load_val (sat_field(bus.load_sec, SEC_LIM)),
    .i_en       (w_dec),
    .o_cnt      (w_sec),
    .o_borrow   (w_borrow)
  );

  always_comb begin
    w_next = r_state;
    if (bus.load) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_start_ok) w_next = ST_RUN;
        ST_RUN: begin
          if (bus.pause)   w_next = ST_PAUSED;
          else if (w_last) w_next = ST_EXPIRED;
        end
        ST_PAUSED:  if (w_start_ok) w_next = ST_RUN;
        ST_EXPIRED: w_next = ST_EXPIRED;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: state, minutes and status registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_min     <= '0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == ST_RUN);
      r_expired <= w_last;
      if (bus.load) begin
        r_min <= sat_field(bus.load_min, MIN_LIM);
      end else if (w_borrow && (r_min != '0)) begin
        r_min <= r_min - 1'b1;
      end
    end
  end

  assign bus.q_seconds = w_sec;
  assign bus.q_minutes = r_min;
  assign bus.running   = r_running;
  assign bus.expired   = r_expired;

`ifdef COUNTDOWN_ALARM_EN
  localparam int ACNT_W = ($clog2(ALARM_TICKS + 1) < 1) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_TICKS - 1);

  logic              r_alarm;
  logic [ACNT_W-1:0] r_acnt;

  // ---- stage p0: alarm hold counter ----
  // The tick that causes expiry is not counted; ALARM_TICKS further ticks are.
  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      r_alarm <= 1'b0;
      r_acnt  <= '0;
    end else if (w_last) begin
      r_alarm <= 1'b1;
      r_acnt  <= '0;
    end else if (r_alarm && bus.tc_time_base) begin
      if (r_acnt == ACNT_LAST) begin
        r_alarm <= 1'b0;
        r_acnt  <= '0;
      end else begin
        r_acnt  <= r_acnt + 1'b1;
      end
    end
  end

  assign bus.alarm = r_alarm;
`else
  assign bus.alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int MAXM = 59;
  localparam int ATK  = 3;
`ifdef COUNTDOWN_ALARM_EN
  localparam bit ALM_EN = 1'b1;
`else
  localparam bit ALM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown_timer_if ifc ();

  countdown_timer #(.MAX_MIN(MAXM), .ALARM_TICKS(ATK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: total remaining seconds plus "counting" / "finished" flags.
  int m_total;
  bit m_run, m_done, m_exp, m_alarm;
  int m_acnt;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step(input bit r, t, l, input int lm, ls, input bit s, p);
    m_exp = 1'b0;
    if (r) begin
      m_total = 0; m_run = 0; m_done = 0;
    end else if (l) begin
      m_total = sat(lm, MAXM) * 60 + sat(ls, 59); m_run = 0; m_done = 0;
    end else if (p) begin
      m_run = 0;
    end else if (s && !m_run && !m_done && m_total != 0) begin
      m_run = 1;
    end else if (m_run && t) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_exp = 1; m_run = 0; m_done = 1;
      end
    end
    if (!ALM_EN || r || l) begin
      m_alarm = 0; m_acnt = 0;
    end else if (m_exp) begin
      m_alarm = 1; m_acnt = 0;
    end else if (m_alarm && t) begin
      m_acnt++;
      if (m_acnt == ATK) begin m_alarm = 0; m_acnt = 0; end
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {ifc.q_minutes, ifc.q_seconds, ifc.running, ifc.expired, ifc.alarm};
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got min=%0d sec=%0d run=%b exp=%b alm=%b, required min=%0d sec=%0d run=%b exp=%b alm=%b",
               name, got[14:9], got[8:3], got[2], got[1], got[0],
               exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one clock of inputs, advance the model, compare after the edge.
  task automatic drive(input string name, input bit r, t, l, input int lm, ls, input bit s, p);
    logic [14:0] mexp;
    reset            = r;
    ifc.tc_time_base = t;
    ifc.load         = l;
    ifc.load_min     = 6'(lm);
    ifc.load_sec     = 6'(ls);
    ifc.start        = s;
    ifc.pause        = p;
    @(posedge clk);
    model_step(r, t, l, lm, ls, s, p);
    @(negedge clk);
    mexp = {6'(m_total / 60), 6'(m_total % 60), m_run, m_exp, m_alarm};
    check(name, dut_vec(), mexp);
  endtask

  typedef struct {
    bit rst, tick, ld;
    int lm, ls;
    bit st, ps;
    int em, es;
    bit er, ee;
  } vec_t;

  function automatic vec_t mk(bit rst, tick, ld, int lm, ls, bit st, ps, int em, es, bit er, ee);
    vec_t v;
    v.rst = rst; v.tick = tick; v.ld = ld; v.lm = lm; v.ls = ls; v.st = st; v.ps = ps;
    v.em = em; v.es = es; v.er = er; v.ee = ee;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [14:0] g;
    //            rst tk ld lm ls st ps   em es er ee
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));  // reset
    tbl.push_back(mk(0, 0, 1, 0, 3, 0, 0,  0, 3, 0, 0));  // load 00:03
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 3, 1, 0));  // start
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1));  // expiry pulse
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));  // pulse is one clock
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));  // no wrap below 0
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0));  // start ignored when expired
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0));  // load 01:00
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 59, 1, 0)); // borrow, no expiry
    tbl.push_back(mk(0, 0, 1, 0, 63, 0, 0, 0, 59, 0, 0)); // sec saturates
    tbl.push_back(mk(0, 0, 1, 63, 63, 0, 0, 59, 59, 0, 0)); // min saturates
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0));  // load 00:00
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0));  // start ignored at zero
    tbl.push_back(mk(0, 0, 1, 0, 5, 0, 0,  0, 5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0,  0, 5, 1, 0));  // start+tick: no decrement
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 4, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  0, 4, 0, 0));  // pause+tick: no decrement
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,  0, 4, 0, 0));  // paused ignores tick
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  0, 4, 0, 0));  // pause outranks start
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 4, 1, 0));  // resume
    tbl.push_back(mk(0, 1, 1, 0, 9, 0, 0,  0, 9, 0, 0));  // load discards tick
    tbl.push_back(mk(0, 1, 1, 2, 0, 1, 1,  2, 0, 0, 0));  // load outranks all

    reset = 1'b1; ifc.tc_time_base = 0; ifc.load = 0; ifc.load_min = 0;
    ifc.load_sec = 0; ifc.start = 0; ifc.pause = 0;
    m_total = 0; m_run = 0; m_done = 0; m_exp = 0; m_alarm = 0; m_acnt = 0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      drive($sformatf("tbl%0d_model", i), tbl[i].rst, tbl[i].tick, tbl[i].ld,
            tbl[i].lm, tbl[i].ls, tbl[i].st, tbl[i].ps);
      g = dut_vec();
      check($sformatf("tbl%0d", i), {g[14:1], 1'b0},
            {6'(tbl[i].em), 6'(tbl[i].es), tbl[i].er, tbl[i].ee, 1'b0});
    end

    // Pause and resume: 00:10, 2 ticks, pause, 5 ticks, start, 1 tick -> 00:07.
    drive("pr_load", 0, 0, 1, 0, 10, 0, 0);
    drive("pr_start", 0, 0, 0, 0, 0, 1, 0);
    repeat (2) drive("pr_tick", 0, 1, 0, 0, 0, 0, 0);
    drive("pr_pause", 0, 0, 0, 0, 0, 0, 1);
    repeat (5) drive("pr_ptick", 0, 1, 0, 0, 0, 0, 0);
    drive("pr_resume", 0, 0, 0, 0, 0, 1, 0);
    drive("pr_tick2", 0, 1, 0, 0, 0, 0, 0);
    check("pause_resume", dut_vec(), {6'd0, 6'd7, 1'b1, 1'b0, 1'b0});

    // Reset mid-run: 02:30, 4 ticks -> 02:26, then reset abandons the count.
    drive("rr_load", 0, 0, 1, 2, 30, 0, 0);
    drive("rr_start", 0, 0, 0, 0, 0, 1, 0);
    repeat (4) drive("rr_tick", 0, 1, 0, 0, 0, 0, 0);
    check("reset_pre", dut_vec(), {6'd2, 6'd26, 1'b1, 1'b0, 1'b0});
    drive("rr_reset", 1, 1, 0, 0, 0, 0, 0);
    check("reset_mid", dut_vec(), 15'd0);
    drive("rr_after", 0, 1, 0, 0, 0, 0, 0);
    check("reset_idle", dut_vec(), 15'd0);

    // Alarm hold for ATK ticks, then clear by load during the alarm.
    drive("al_load", 0, 0, 1, 0, 1, 0, 0);
    drive("al_start", 0, 0, 0, 0, 0, 1, 0);
    drive("al_exp", 0, 1, 0, 0, 0, 0, 0);
    check("alarm_rise", dut_vec(), {6'd0, 6'd0, 1'b0, 1'b1, ALM_EN});
    drive("al_t1", 0, 1, 0, 0, 0, 0, 0);
    drive("al_idle", 0, 0, 0, 0, 0, 0, 0);
    drive("al_t2", 0, 1, 0, 0, 0, 0, 0);
    check("alarm_hold", dut_vec(), {6'd0, 6'd0, 1'b0, 1'b0, ALM_EN});
    drive("al_t3", 0, 1, 0, 0, 0, 0, 0);
    check("alarm_clear", dut_vec(), 15'd0);
    drive("al_load2", 0, 0, 1, 0, 1, 0, 0);
    drive("al_start2", 0, 0, 0, 0, 0, 1, 0);
    drive("al_exp2", 0, 1, 0, 0, 0, 0, 0);
    drive("al_t1b", 0, 1, 0, 0, 0, 0, 0);
    check("alarm_hold2", dut_vec(), {6'd0, 6'd0, 1'b0, 1'b0, ALM_EN});
    drive("al_ldclr", 0, 0, 1, 0, 4, 0, 0);
    check("alarm_load_clr", dut_vec(), {6'd0, 6'd4, 1'b0, 1'b0, 1'b0});

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, t, l, s, p;
      int lm, ls;
      r  = ($urandom_range(0, 199) == 0);
      t  = ($urandom_range(0, 9) < 4);
      l  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 29) == 0);
      lm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      drive("rand", r, t, l, lm, ls, s, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX_MIN, default 59: the largest minutes value accepted at load.
REQ-002 Parameter ALARM_TICKS, default 10: the number of time-base ticks the alarm holds after expiry.
REQ-003 Port clk, input, 1: the single system clock.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port tc_time_base, input, 1: one-clock-wide 1 Hz tick from the time-base generator.
REQ-006 Port load, input, 1: single-clock strobe that loads the preset value.
REQ-007 Port load_min, input, 6: preset minutes.
REQ-008 Port load_sec, input, 6: preset seconds.
REQ-009 Port start, input, 1: single-clock strobe that starts or resumes counting.
REQ-010 Port pause, input, 1: single-clock strobe that freezes counting.
REQ-011 Port q_seconds, output, 6: remaining seconds, range 0..59.
REQ-012 Port q_minutes, output, 6: remaining minutes, range 0..MAX_MIN.
REQ-013 Port running, output, 1: high while in the RUN state.
REQ-014 Port expired, output, 1: one-clock pulse when the count reaches 00:00.
REQ-015 Port alarm, output, 1: held alarm indication (see Configuration).

Function
REQ-016 The block SHALL implement a four-state FSM: IDLE, RUN, PAUSED, EXPIRED.
REQ-017 Command priority SHALL be reset > load > pause > start when strobes coincide.
REQ-018 Load, from any state, SHALL set the count to {load_min, load_sec} and enter IDLE on the next clock.
REQ-019 A load_sec value above 59 SHALL saturate to 59, and a load_min value above MAX_MIN SHALL saturate to MAX_MIN.
REQ-020 Start SHALL move IDLE->RUN or PAUSED->RUN only if the count is nonzero; otherwise start is ignored.
REQ-021 Start in RUN or EXPIRED SHALL be ignored.
REQ-022 Pause SHALL move RUN->PAUSED and SHALL be ignored in every other state.
REQ-023 In RUN, each tc_time_base SHALL decrement the count by one second, with outputs registered and updated one clock after the tick.
REQ-024 When seconds is 0 and minutes is greater than 0, a tick SHALL set seconds to 59 and decrement minutes by 1.
REQ-025 A tick that takes the count from 00:01 to 00:00 SHALL move the FSM to EXPIRED and assert expired for exactly one clock, in the same clock the 00:00 value appears.
REQ-026 A tick arriving in the same clock as start SHALL NOT decrement; counting begins with the next tick.
REQ-027 A tick arriving in the same clock as pause SHALL NOT decrement.
REQ-028 A tick arriving in the same clock as load SHALL be discarded.
REQ-029 Ticks SHALL be ignored in IDLE, PAUSED and EXPIRED; the count never wraps below 00:00.
REQ-030 EXPIRED SHALL be left only by load or reset.
REQ-031 The running output SHALL equal (state == RUN), registered.

Reset
REQ-032 While reset is high on a clock edge, the block SHALL enter IDLE with q_seconds = 0, q_minutes = 0, running = 0, expired = 0, alarm = 0 and the alarm counter at 0.
REQ-033 Reset asserted mid-count SHALL abandon the count without asserting expired.

Configuration
REQ-034 With COUNTDOWN_ALARM_EN defined, alarm SHALL rise together with expired and stay high for ALARM_TICKS time-base ticks.
REQ-035 With COUNTDOWN_ALARM_EN defined, alarm SHALL then clear on the clock after the ALARM_TICKS-th tick, or immediately on load or reset.
REQ-036 Without COUNTDOWN_ALARM_EN, alarm SHALL be tied to 0 and no alarm counter logic SHALL be synthesised.

Structure
REQ-037 The shared package countdown_pkg SHALL hold the FSM state encoding (2-bit IDLE=0, RUN=1, PAUSED=2, EXPIRED=3) and the constants SEC_MAX=59 and SEC_W=6.
REQ-038 One sub-module, down_cnt_mod60, SHALL implement the seconds digit: a 6-bit down counter with load, enable and borrow-out, where borrow-out drives the minutes decrement.

Verification
REQ-039 Scenario, basic countdown: load 00:03, start, then 3 ticks -> q_seconds goes 2, 1, 0; expired pulses once with the 0; running drops.
REQ-040 Scenario, minutes borrow: load 01:00, start, then 1 tick -> q_minutes = 0, q_seconds = 59, and no expired pulse.
REQ-041 Scenario, pause and resume: load 00:10, start, 2 ticks, pause, 5 ticks, start, 1 tick -> q_seconds = 7.
REQ-042 Scenario, boundaries: load with load_sec = 63 -> q_seconds = 59; load 00:00 then start -> remains IDLE with running = 0; start and tick in the same clock -> no decrement.
REQ-043 Scenario, reset mid-run: load 02:30, start, 4 ticks, reset -> all outputs 0, state IDLE, no expired pulse.
REQ-044 Scenario, alarm with COUNTDOWN_ALARM_EN and ALARM_TICKS = 3: expiry -> alarm high for 3 ticks, then low; a load during the alarm clears it on the next clock.
